// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: op codes,
// status-register bit positions, sequencer states and per-op flag masks.
package alu_pkg;

  // ALU op codes (12..15 are illegal)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SBC  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_EOR  = 4'd4;
  localparam logic [3:0] OP_ORA  = 4'd5;
  localparam logic [3:0] OP_BIT  = 4'd6;
  localparam logic [3:0] OP_ASL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  // P register bit positions; bit 2 is reserved and never touched by commits
  localparam int unsigned STATUS_C = 7;
  localparam int unsigned STATUS_Z = 6;
  localparam int unsigned STATUS_I = 5;
  localparam int unsigned STATUS_D = 4;
  localparam int unsigned STATUS_B = 3;
  localparam int unsigned STATUS_V = 1;
  localparam int unsigned STATUS_N = 0;

  // Sequencer states, encodings kept identical to the legacy constants
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op > OP_PASS);
  endfunction

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_ASL) || (op == OP_LSR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // Which P bits an op is allowed to update from the ALU's status_out
  function automatic logic [7:0] flag_mask(input logic [3:0] op);
    logic [7:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_ADC, OP_SBC: begin
        m[STATUS_C] = 1'b1;
        m[STATUS_Z] = 1'b1;
        m[STATUS_V] = 1'b1;
        m[STATUS_N] = 1'b1;
      end
      OP_AND, OP_EOR, OP_ORA, OP_PASS: begin
        m[STATUS_Z] = 1'b1;
        m[STATUS_N] = 1'b1;
      end
      OP_BIT: begin
        m[STATUS_Z] = 1'b1;
        m[STATUS_V] = 1'b1;
        m[STATUS_N] = 1'b1;
      end
      OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
        m[STATUS_C] = 1'b1;
        m[STATUS_Z] = 1'b1;
        m[STATUS_N] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_flag_merge.sv
// Combinational merge of ALU status_out into the architectural P register:
// bits selected by mask come from status_out, all others keep p_old.
module alu_flag_merge (
  input  logic [7:0] p_old,
  input  logic [7:0] status_out,
  input  logic [7:0] mask,
  output logic [7:0] p_new
);

  // Per-bit select between old P and ALU status
  always_comb begin
    p_new = (p_old & ~mask) | (status_out & mask);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the ALU: accepts one op per request,
// drives the ALU inputs, waits out the ALU latency, commits A/P and
// returns a response. Also applies direct flag writes while idle.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter logic [7:0]  RESET_A = 8'h00,
  parameter logic [7:0]  RESET_P = 8'h20,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_operand,
  input  logic       req_tgt,
  input  logic       flag_valid,
  output logic       flag_ready,
  input  logic [2:0] flag_idx,
  input  logic       flag_val,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic [3:0] alu_op,
  output logic [7:0] alu_acc,
  output logic [7:0] alu_operand,
  output logic [7:0] alu_status,
  input  logic [7:0] alu_result,
  input  logic [7:0] alu_status_out,
  output logic [7:0] a_reg,
  output logic [7:0] p_reg
);

  localparam int unsigned CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  state_t           state;
  logic [3:0]       op_q;
  logic             tgt_q;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       p_new;
  logic [7:0]       commit_mask;

  // Handshake readiness and ALU inputs that simply mirror A/P
  // (A/P cannot change between accept and capture, so they stay stable)
  always_comb begin
    req_ready   = (state == ST_IDLE);
    flag_ready  = (state == ST_IDLE) && !req_valid;
    alu_acc     = a_reg;
    alu_status  = p_reg;
    commit_mask = flag_mask(op_q);
  end

  alu_flag_merge u_flag_merge (
    .p_old      (p_reg),
    .status_out (alu_status_out),
    .mask       (commit_mask),
    .p_new      (p_new)
  );

  // Sequencer: accept, issue, wait for ALU result, commit, respond.
  // alu_op/alu_operand are loaded on the accept edge so they are already
  // valid throughout ISSUE, when the ALU samples them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_PASS;
      tgt_q       <= 1'b0;
      cnt         <= '0;
      a_reg       <= RESET_A;
      p_reg       <= RESET_P;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      alu_op      <= OP_PASS;
      alu_operand <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            tgt_q <= req_tgt;
            if (op_is_illegal(req_op)) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state       <= ST_ISSUE;
              alu_op      <= req_op;
              alu_operand <= (op_is_shift(req_op) && !req_tgt) ? a_reg : req_operand;
            end
          end else if (flag_valid) begin
            p_reg[flag_idx] <= flag_val;
          end
        end

        ST_ISSUE: begin
          cnt   <= CNT_W'(ALU_LAT);
          state <= ST_EXEC;
        end

        ST_EXEC: begin
          if (cnt == CNT_W'(1)) begin
            resp_data  <= alu_result;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            p_reg      <= p_new;
            if ((op_q != OP_BIT) && !tgt_q) begin
              a_reg <= alu_result;
            end
            state <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
